// File: rtl/div_iter_pkg.sv
// -----------------------------------------------------------------------------
// div_iter_pkg
//   Shared definitions for the iterative EX-stage divider: FSM state
//   encodings, the default operand width and the fixed divide-by-zero result.
// -----------------------------------------------------------------------------
package div_iter_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_DONE   = 2'b11
    } div_state_e;

    // Divide-by-zero is architecturally undefined; a fixed zero keeps HI/LO
    // deterministic.
    localparam logic [2*DIV_WIDTH-1:0] DIV_RESULT_ZERO = '0;

endpackage : div_iter_pkg

// File: rtl/div_iter_if.sv
// -----------------------------------------------------------------------------
// div_iter_if
//   Request/response bundle between EX divide control and the divider.
//     div_start  : request, held by control until div_ready is seen
//     div_signed : 1 = DIV (two's complement), 0 = DIVU
//     opdata_a   : dividend (rs)
//     opdata_b   : divisor (rt)
//     annul      : flush/exception, aborts an operation in progress
//     div_ready  : one-cycle pulse, div_result valid in that cycle
//     div_result : {remainder -> HI, quotient -> LO}
//   master = EX control side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_iter_if
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic               div_start;
    logic               div_signed;
    logic [WIDTH-1:0]   opdata_a;
    logic [WIDTH-1:0]   opdata_b;
    logic               annul;
    logic               div_ready;
    logic [2*WIDTH-1:0] div_result;

    modport master (
        output div_start,
        output div_signed,
        output opdata_a,
        output opdata_b,
        output annul,
        input  div_ready,
        input  div_result
    );

    modport slave (
        input  div_start,
        input  div_signed,
        input  opdata_a,
        input  opdata_b,
        input  annul,
        output div_ready,
        output div_result
    );
endinterface : div_iter_if

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
//   Iterative radix-2 restoring divider for the MIPS32 EX stage. One quotient
//   bit per cycle; the pipeline stalls while it is busy.
//   Ports:
//     clk : core clock, rising edge
//     rst : asynchronous active-low reset
//     bus : div_iter_if.slave (start/signed/operands/annul in, ready/result out)
//   Timing: request captured at edge E0, ready high in the cycle after E33
//   (WIDTH+1); divide-by-zero gives ready in the cycle after E2.
// -----------------------------------------------------------------------------
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
)(
    input  logic         clk,
    input  logic         rst,
    div_iter_if.slave    bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e         state_q,     state_d;
    logic [CNT_W-1:0]   counter_q,   counter_d;
    logic [WIDTH-1:0]   dividend_q,  dividend_d;   // dividend bits out, quotient bits in
    logic [WIDTH-1:0]   divisor_q,   divisor_d;
    logic [WIDTH:0]     rem_q,       rem_d;        // partial remainder
    logic               quot_neg_q,  quot_neg_d;   // a[msb] ^ b[msb] for DIV
    logic               rem_neg_q,   rem_neg_d;    // a[msb] for DIV
    logic               ready_q,     ready_d;
    logic [2*WIDTH-1:0] result_q,    result_d;

    // Single restoring step
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               abort;

    always_comb begin
        shifted  = {rem_q[WIDTH-1:0], dividend_q[WIDTH-1]};
        diff     = shifted - {1'b0, divisor_q};
        // Borrow out of the WIDTH+1-bit subtract means the trial failed.
        rem_step = diff[WIDTH] ? shifted : diff;
        quo_step = {dividend_q[WIDTH-2:0], ~diff[WIDTH]};
        quo_fix  = quot_neg_q ? -quo_step : quo_step;
        rem_fix  = rem_neg_q  ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
        abort    = bus.annul | ~bus.div_start;
    end

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        ready_d    = 1'b0;
        result_d   = result_q;

        case (state_q)
            DIV_IDLE: begin
                if (bus.div_start && !bus.annul) begin
                    // Raw operands are latched; absolute values are formed on
                    // the first ON edge to keep negation off the capture path.
                    dividend_d = bus.opdata_a;
                    divisor_d  = bus.opdata_b;
                    rem_d      = '0;
                    counter_d  = '0;
                    rem_neg_d  = bus.div_signed & bus.opdata_a[WIDTH-1];
                    quot_neg_d = bus.div_signed &
                                 (bus.opdata_a[WIDTH-1] ^ bus.opdata_b[WIDTH-1]);
                    state_d    = (bus.opdata_b == '0) ? DIV_BYZERO : DIV_ON;
                end
            end

            DIV_BYZERO: begin
                // Two cycles here keeps the zero-divisor ready at E2, in step
                // with the operand-conditioning cycle of the normal path.
                if (abort) begin
                    state_d = DIV_IDLE;
                end else if (counter_q == CNT_W'(1)) begin
                    state_d  = DIV_DONE;
                    result_d = (2*WIDTH)'(DIV_RESULT_ZERO);
                    ready_d  = 1'b1;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end

            DIV_ON: begin
                if (abort) begin
                    state_d = DIV_IDLE;
                end else if (counter_q == '0) begin
                    // Operand conditioning: the divisor is negative exactly
                    // when the two sign flags differ. Absolute values are
                    // plain unsigned WIDTH bits, so the most negative value
                    // maps to itself and there is no overflow case.
                    dividend_d = rem_neg_q ? -dividend_q : dividend_q;
                    divisor_d  = (quot_neg_q ^ rem_neg_q) ? -divisor_q : divisor_q;
                    counter_d  = CNT_W'(1);
                end else begin
                    dividend_d = quo_step;
                    rem_d      = rem_step;
                    counter_d  = counter_q + CNT_W'(1);
                    if (counter_q == CNT_W'(WIDTH)) begin
                        state_d  = DIV_DONE;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end
                end
            end

            DIV_DONE: begin
                // Requests seen here are ignored; only IDLE accepts.
                state_d = DIV_IDLE;
            end

            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_IDLE;
            counter_q  <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            ready_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
        end
    end

    assign bus.div_ready  = ready_q;
    assign bus.div_result = result_q;

endmodule : div_iter

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter
//   Directed bench for div_iter: unsigned/signed divides, boundary operands,
//   divide-by-zero, annul abort, start drop, asynchronous reset mid-operation
//   and back-to-back operations.
// -----------------------------------------------------------------------------
module tb_div_iter;
    import div_iter_pkg::*;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    div_iter_if #(.WIDTH(32)) bus ();

    div_iter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge. The next edge is E0.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int exp_lat, input logic [63:0] exp_res);
        int lat;
        lat = -1;
        bus.div_start  = 1'b1;
        bus.div_signed = s;
        bus.opdata_a   = a;
        bus.opdata_b   = b;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.div_ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        check_int({tag, "_latency"}, lat, exp_lat);
        check64({tag, "_result"}, bus.div_result, exp_res);
        $display("op %s a=%h b=%h signed=%0d -> ready after E%0d result=%h",
                 tag, a, b, s, lat, bus.div_result);
        bus.div_start = 1'b0;
        @(posedge clk);
        #1;
        check_int({tag, "_ready_pulse"}, int'(bus.div_ready), 0);
        check64({tag, "_result_hold"}, bus.div_result, exp_res);
    endtask

    // Watch n cycles and require that no ready pulse appears.
    task automatic expect_no_ready(input string tag, input int n);
        int pulses;
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (bus.div_ready === 1'b1) pulses++;
        end
        check_int({tag, "_no_ready"}, pulses, 0);
        $display("abort %s: %0d ready pulses in %0d cycles", tag, pulses, n);
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.opdata_a   = '0;
        bus.opdata_b   = '0;
        bus.annul      = 1'b0;

        #2 rst = 1'b0;
        #1;
        check_int("reset_ready", int'(bus.div_ready), 0);
        check64("reset_result", bus.div_result, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        run_op("divu_100_7",   32'd100,        32'd7,          1'b0, 33, {32'd2, 32'd14});
        run_op("divu_min_m1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 33, {32'h8000_0000, 32'h0});
        run_op("div_byzero",   32'd123,        32'd0,          1'b1, 2,  64'h0);
        run_op("div_m7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("divu_byzero",  32'hDEAD_BEEF,  32'd0,          1'b0, 2,  64'h0);
        run_op("div_7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, 33, {32'h0000_0001, 32'hFFFF_FFFD});
        run_op("div_min_m1",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 33, {32'h0, 32'h8000_0000});
        run_op("div_zero_dvd", 32'd0,          32'd5,          1'b1, 33, 64'h0);
        run_op("divu_17_5",    32'd17,         32'd5,          1'b0, 33, {32'd2, 32'd3});

        // Annul pulsed in the middle of the iterations.
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.opdata_a   = 32'd1000;
        bus.opdata_b   = 32'd3;
        repeat (11) @(posedge clk);
        #1 bus.annul = 1'b1;
        @(posedge clk);
        #1;
        bus.annul     = 1'b0;
        bus.div_start = 1'b0;
        expect_no_ready("annul", 40);
        check64("annul_result_hold", bus.div_result, {32'd2, 32'd3});
        run_op("divu_9_3", 32'd9, 32'd3, 1'b0, 33, {32'd0, 32'd3});

        // Start dropped mid-operation.
        bus.div_start  = 1'b1;
        bus.opdata_a   = 32'd77;
        bus.opdata_b   = 32'd4;
        repeat (6) @(posedge clk);
        #1 bus.div_start = 1'b0;
        expect_no_ready("start_drop", 40);

        // Asynchronous reset in the middle of ON, away from any clock edge.
        bus.div_start  = 1'b1;
        bus.opdata_a   = 32'd500;
        bus.opdata_b   = 32'd6;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_int("async_rst_ready", int'(bus.div_ready), 0);
        check64("async_rst_result", bus.div_result, 64'h0);
        $display("async reset asserted mid-operation: ready=%0d result=%h",
                 bus.div_ready, bus.div_result);
        bus.div_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        expect_no_ready("after_reset", 40);

        // Back-to-back: next request raised one cycle after the ready cycle.
        run_op("b2b_50_5", 32'd50, 32'd5, 1'b0, 33, {32'd0, 32'd10});
        run_op("b2b_51_5", 32'd51, 32'd5, 1'b0, 33, {32'd1, 32'd10});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_div_iter
